// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for a single memory port.
// One transaction at a time: IDLE -> WAIT (mem_req held until ack or timeout) -> RESP.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp0_err,
   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  rsp1_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  owner
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          gnt0, gnt1;
   logic          done;
   logic [DATA_WIDTH-1:0] cap;

   // owner doubles as last_grant: on a tie the port that did not win last time goes.
   assign gnt0 = !rst && (state == IDLE) && req0_valid && (!req1_valid || owner);
   assign gnt1 = !rst && (state == IDLE) && req1_valid && (!req0_valid || !owner);
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign busy = (state != IDLE);

   // ack wins over timeout on the last allowed cycle
   assign done = mem_ack || (cnt == CNT_LAST);
   assign cap  = (mem_ack && !mem_we) ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
         rsp1_err   <= 1'b0;
         owner      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  state     <= WAIT;
                  mem_req   <= 1'b1;
                  mem_we    <= gnt1 ? req1_we    : req0_we;
                  mem_addr  <= gnt1 ? req1_addr  : req0_addr;
                  mem_wdata <= gnt1 ? req1_wdata : req0_wdata;
                  owner     <= gnt1;
                  cnt       <= '0;
               end
            end
            WAIT: begin
               if (done) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  rsp0_valid <= !owner;
                  rsp1_valid <= owner;
                  rsp0_err   <= !owner && !mem_ack;
                  rsp1_err   <= owner && !mem_ack;
                  rsp0_rdata <= owner ? '0 : cap;
                  rsp1_rdata <= owner ? cap : '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               state      <= IDLE;
               rsp0_valid <= 1'b0;
               rsp0_rdata <= '0;
               rsp0_err   <= 1'b0;
               rsp1_valid <= 1'b0;
               rsp1_rdata <= '0;
               rsp1_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-phase model.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, rsp0_rdata;
   logic          req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, rsp1_rdata;
   logic          mem_req, mem_we, mem_ack, busy, owner;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: a transaction is either absent (m_free), in its memory phase
   // (m_done=0, counting cycles in m_j), or in its single response cycle.
   bit          m_init = 0, m_free = 1, m_done = 0, m_last = 1, m_port = 0;
   bit          m_we = 0, m_err = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0, m_data = '0;
   int          m_j = 0;
   bit          acc0 = 0, acc1 = 0;

   always @(negedge clk) begin : mdl
      bit e_r0, e_r1, e_rsp;
      e_r0  = !rst && m_free && req0_valid && (!req1_valid || m_last);
      e_r1  = !rst && m_free && req1_valid && (!req0_valid || !m_last);
      e_rsp = !m_free && m_done;
      if (m_init) begin
         chk("m_req0_ready", req0_ready, e_r0);
         chk("m_req1_ready", req1_ready, e_r1);
         chk("m_busy", busy, !m_free);
         chk("m_mem_req", mem_req, !m_free && !m_done);
         chk("m_owner", owner, m_last);
         chk("m_mem_we", mem_we, m_we);
         chk("m_mem_addr", mem_addr, m_addr);
         chk("m_mem_wdata", mem_wdata, m_wdata);
         chk("m_rsp0_valid", rsp0_valid, e_rsp && !m_port);
         chk("m_rsp1_valid", rsp1_valid, e_rsp && m_port);
         if (e_rsp) begin
            chk("m_rsp0_rdata", rsp0_rdata, m_port ? 64'd0 : m_data);
            chk("m_rsp1_rdata", rsp1_rdata, m_port ? m_data : 64'd0);
            chk("m_rsp0_err", rsp0_err, !m_port && m_err);
            chk("m_rsp1_err", rsp1_err, m_port && m_err);
         end
      end
      acc0 = e_r0;
      acc1 = e_r1;
      if (rst) begin
         m_free = 1; m_done = 0; m_last = 1; m_we = 0; m_addr = '0; m_wdata = '0;
         m_init = 1;
      end else if (!m_free && m_done) begin
         m_free = 1;
      end else if (!m_free) begin
         if (mem_ack) begin
            m_done = 1; m_err = 0; m_data = m_we ? 64'd0 : mem_rdata;
         end else if (m_j == TO - 1) begin
            m_done = 1; m_err = 1; m_data = '0;
         end else begin
            m_j++;
         end
      end else if (e_r0 || e_r1) begin
         m_free = 0; m_done = 0; m_j = 0; m_port = e_r1; m_last = e_r1;
         m_we    = e_r1 ? req1_we    : req0_we;
         m_addr  = e_r1 ? req1_addr  : req0_addr;
         m_wdata = e_r1 ? req1_wdata : req0_wdata;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      req0_valid = 1; req0_we = 0; req0_addr = 32'h100; req0_wdata = '0;
      req1_valid = 1; req1_we = 0; req1_addr = 32'h200; req1_wdata = '0;
      mem_ack = 0; mem_rdata = '0;

      // reset with both requests pending
      tick;
      chk("rst_ready0_a", req0_ready, 0);
      chk("rst_ready1_a", req1_ready, 0);
      tick;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_owner", owner, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      rst = 0;
      mem_ack = 1;
      #1;

      // tie with zero-wait memory: port 0 first, alternating every 3 cycles
      for (int i = 0; i < 12; i++) begin
         chk("tie_ready0", req0_ready, (i % 6) == 0);
         chk("tie_ready1", req1_ready, (i % 6) == 3);
         tick;
      end
      req0_valid = 0; req1_valid = 0; mem_ack = 0;

      // single read from port 1, ack two cycles after mem_req rises
      req1_valid = 1; req1_we = 0; req1_addr = 32'h0000_1A40;
      #1;
      chk("rd_ready1", req1_ready, 1);
      chk("rd_ready0", req0_ready, 0);
      tick; req1_valid = 0;
      chk("rd_mem_req1", mem_req, 1);
      chk("rd_mem_addr", mem_addr, 32'h0000_1A40);
      tick;
      chk("rd_mem_req2", mem_req, 1);
      tick;
      chk("rd_mem_req3", mem_req, 1);
      mem_ack = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
      tick; mem_ack = 0;
      chk("rd_rsp1_valid", rsp1_valid, 1);
      chk("rd_rsp1_rdata", rsp1_rdata, 64'hDEAD_BEEF_0123_4567);
      chk("rd_rsp1_err", rsp1_err, 0);
      chk("rd_rsp0_valid", rsp0_valid, 0);
      chk("rd_mem_req_off", mem_req, 0);
      tick;
      chk("rd_idle", busy, 0);

      // write from port 1; request fields change after accept, mem side must hold
      req1_valid = 1; req1_we = 1; req1_addr = 32'h2000; req1_wdata = 64'hAAAA_5555_AAAA_5555;
      #1;
      chk("wr_ready1", req1_ready, 1);
      tick; req1_valid = 0; req1_we = 0; req1_wdata = '0;
      chk("wr_mem_we1", mem_we, 1);
      chk("wr_mem_wdata1", mem_wdata, 64'hAAAA_5555_AAAA_5555);
      tick;
      chk("wr_mem_we2", mem_we, 1);
      chk("wr_mem_wdata2", mem_wdata, 64'hAAAA_5555_AAAA_5555);
      mem_ack = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
      tick; mem_ack = 0;
      chk("wr_rsp1_valid", rsp1_valid, 1);
      chk("wr_rsp1_rdata", rsp1_rdata, 0);
      chk("wr_rsp1_err", rsp1_err, 0);
      tick;

      // timeout with no ack, then ack on the final allowed cycle
      for (int r = 0; r < 2; r++) begin
         req0_valid = 1; req0_we = 0; req0_addr = 32'h3000 + r; mem_rdata = '1;
         #1;
         chk("to_ready0", req0_ready, 1);
         for (int k = 1; k <= TO; k++) begin
            tick;
            if (k == 1) req0_valid = 0;
            chk("to_mem_req", mem_req, 1);
            if (r == 1 && k == TO) begin
               mem_ack = 1; mem_rdata = 64'h0BAD_F00D_0000_0001;
            end
         end
         tick; mem_ack = 0;
         chk("to_rsp0_valid", rsp0_valid, 1);
         chk("to_rsp0_err", rsp0_err, r == 0);
         chk("to_rsp0_rdata", rsp0_rdata, (r == 0) ? 64'd0 : 64'h0BAD_F00D_0000_0001);
         chk("to_mem_req_off", mem_req, 0);
         tick;
      end

      // reset in the second WAIT cycle abandons the transaction
      req0_valid = 1; req0_we = 0; req0_addr = 32'h4000;
      #1;
      chk("mr_ready0", req0_ready, 1);
      tick; req0_valid = 0;
      tick; rst = 1;
      tick; rst = 0;
      chk("mr_mem_req", mem_req, 0);
      chk("mr_busy", busy, 0);
      chk("mr_owner", owner, 1);
      for (int i = 0; i < 4; i++) begin
         chk("mr_no_rsp0", rsp0_valid, 0);
         chk("mr_no_rsp1", rsp1_valid, 0);
         tick;
      end

      // stray ack in IDLE
      mem_ack = 1;
      tick; mem_ack = 0;
      chk("sa_busy", busy, 0);
      chk("sa_mem_req", mem_req, 0);
      chk("sa_rsp0", rsp0_valid, 0);
      chk("sa_rsp1", rsp1_valid, 0);
      tick;
      chk("sa_rsp0_b", rsp0_valid, 0);
      chk("sa_rsp1_b", rsp1_valid, 0);

      // randomized traffic; requests advance on the model's accept decision
      for (int n = 0; n < 4000; n++) begin
         tick;
         rst = ($urandom_range(0, 299) == 0);
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_we    = 1'($urandom_range(0, 1));
            req0_addr  = $urandom;
            req0_wdata = {$urandom, $urandom};
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_we    = 1'($urandom_range(0, 1));
            req1_addr  = $urandom;
            req1_wdata = {$urandom, $urandom};
         end
         mem_ack   = ($urandom_range(0, 2) == 0);
         mem_rdata = {$urandom, $urandom};
      end
      rst = 0; req0_valid = 0; req1_valid = 0; mem_ack = 0;
      repeat (8) tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
